regfile_writeback: RTL and testbench

- Write-side master for the 32x32 register file: sole driver of its wr_en/wr_addr/wr_data port.
- After reset, sequences a clear of r1..r31, loading SP_INIT into the stack pointer register.
- Then arbitrates ALU and load-unit results onto the single write port, with valid/ready handshakes.
- Exposes a one-entry bypass so operand readers see the write in flight.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/wb_rr_arbiter.sv | 57 +++++
 rtl/regfile_writeback.sv | 164 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file write-back slice.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] SP_ADDR = 5'd29;
    localparam logic [DATA_W-1:0] SP_INIT = 32'd252;

    // Clear index is one bit wider than an address so it can reach NUM_REGS.
    localparam logic [ADDR_W:0]   CLR_FIRST = 6'd1;
    localparam logic [ADDR_W:0]   CLR_END   = 6'd32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

endpackage : regfile_pkg

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin grant for the write-back port.
// Under contention the requester not named by last_grant wins and becomes
// the new last_grant; a lone requester is simply granted.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic enable,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    wb_src_t last_grant_r;
    logic    gnt_alu_s;
    logic    gnt_mem_s;

    // Combinational grant; nothing is granted while disabled.
    always_comb begin
        gnt_alu_s = 1'b0;
        gnt_mem_s = 1'b0;
        if (!enable) begin
            gnt_alu_s = 1'b0;
            gnt_mem_s = 1'b0;
        end else if (req_alu && req_mem) begin
            if (last_grant_r == SRC_ALU) begin
                gnt_mem_s = 1'b1;
            end else begin
                gnt_alu_s = 1'b1;
            end
        end else if (req_alu) begin
            gnt_alu_s = 1'b1;
        end else if (req_mem) begin
            gnt_mem_s = 1'b1;
        end else begin
            gnt_alu_s = 1'b0;
            gnt_mem_s = 1'b0;
        end
    end

    // Remember the winner of each contended cycle.
    always_ff @(posedge clk) begin
        if (nrst) begin
            last_grant_r <= SRC_ALU;
        end else if (enable && req_alu && req_mem) begin
            last_grant_r <= gnt_mem_s ? SRC_MEM : SRC_ALU;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign gnt_alu = gnt_alu_s;
    assign gnt_mem = gnt_mem_s;

endmodule : wb_rr_arbiter

// File: rtl/regfile_writeback.sv
// Write-side master of the 32x32 register file: clears r1..r31 after reset
// (stack pointer gets its initial value), then arbitrates ALU and load
// results onto the single registered write port with a one-entry bypass.
module regfile_writeback
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done,
    output logic              r0_drop,
    input  logic [ADDR_W-1:0] byp_addrA,
    input  logic [ADDR_W-1:0] byp_addrB,
    output logic              byp_hitA,
    output logic              byp_hitB,
    output logic [DATA_W-1:0] byp_dataA,
    output logic [DATA_W-1:0] byp_dataB
);

    wb_state_t         state_r;
    logic [ADDR_W:0]   clr_idx_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              init_done_r;
    logic              r0_drop_r;

    logic              run_s;
    logic              gnt_alu_s;
    logic              gnt_mem_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] src_addr_s;
    logic [DATA_W-1:0] src_data_s;
    logic              hit_a_s;
    logic              hit_b_s;
    logic [DATA_W-1:0] data_a_s;
    logic [DATA_W-1:0] data_b_s;

    assign run_s = (state_r == RUN);

    wb_rr_arbiter u_arb (
        .clk     (clk),
        .nrst    (nrst),
        .enable  (run_s),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu_s),
        .gnt_mem (gnt_mem_s)
    );

    // Select the granted source; a grant is only ever given to a valid source.
    always_comb begin
        xfer_s     = 1'b0;
        src_addr_s = {ADDR_W{1'b0}};
        src_data_s = {DATA_W{1'b0}};
        if (gnt_mem_s) begin
            xfer_s     = 1'b1;
            src_addr_s = mem_addr;
            src_data_s = mem_data;
        end else if (gnt_alu_s) begin
            xfer_s     = 1'b1;
            src_addr_s = alu_addr;
            src_data_s = alu_data;
        end else begin
            xfer_s     = 1'b0;
            src_addr_s = {ADDR_W{1'b0}};
            src_data_s = {DATA_W{1'b0}};
        end
    end

    // Clear sequencer plus registered write port; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r     <= CLEAR;
            clr_idx_r   <= CLR_FIRST;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            init_done_r <= 1'b0;
            r0_drop_r   <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    r0_drop_r <= 1'b0;
                    if (clr_idx_r == CLR_END) begin
                        wr_en_r     <= 1'b0;
                        init_done_r <= 1'b1;
                        state_r     <= RUN;
                    end else begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= clr_idx_r[ADDR_W-1:0];
                        wr_data_r <= (clr_idx_r[ADDR_W-1:0] == SP_ADDR) ? SP_INIT
                                                                         : {DATA_W{1'b0}};
                        clr_idx_r <= clr_idx_r + 6'd1;
                    end
                end
                RUN: begin
                    if (xfer_s && (src_addr_s == {ADDR_W{1'b0}})) begin
                        // r0 is hard zero: accept the result but never write it.
                        wr_en_r   <= 1'b0;
                        r0_drop_r <= 1'b1;
                    end else if (xfer_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= src_addr_s;
                        wr_data_r <= src_data_s;
                        r0_drop_r <= 1'b0;
                    end else begin
                        wr_en_r   <= 1'b0;
                        r0_drop_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= CLEAR;
                    clr_idx_r <= CLR_FIRST;
                    wr_en_r   <= 1'b0;
                    r0_drop_r <= 1'b0;
                end
            endcase
        end
    end

    // Forward the write in flight to operand readers; r0 never forwards.
    always_comb begin
        hit_a_s  = 1'b0;
        hit_b_s  = 1'b0;
        data_a_s = {DATA_W{1'b0}};
        data_b_s = {DATA_W{1'b0}};
        hit_a_s  = wr_en_r && (byp_addrA == wr_addr_r) && (byp_addrA != {ADDR_W{1'b0}});
        hit_b_s  = wr_en_r && (byp_addrB == wr_addr_r) && (byp_addrB != {ADDR_W{1'b0}});
        if (hit_a_s) begin
            data_a_s = wr_data_r;
        end else begin
            data_a_s = {DATA_W{1'b0}};
        end
        if (hit_b_s) begin
            data_b_s = wr_data_r;
        end else begin
            data_b_s = {DATA_W{1'b0}};
        end
    end

    assign alu_ready = gnt_alu_s;
    assign mem_ready = gnt_mem_s;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign init_done = init_done_r;
    assign r0_drop   = r0_drop_r;
    assign byp_hitA  = hit_a_s;
    assign byp_hitB  = hit_b_s;
    assign byp_dataA = data_a_s;
    assign byp_dataB = data_b_s;

endmodule : regfile_writeback

// File: tb/tb_regfile_writeback.sv
// Directed, table-driven bench for regfile_writeback.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        nrst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr, wr_addr, byp_addrA, byp_addrB;
    logic [31:0] alu_data, mem_data, wr_data, byp_dataA, byp_dataB;
    logic        wr_en, init_done, r0_drop, byp_hitA, byp_hitB;

    int checks = 0;
    int errors = 0;

    regfile_writeback dut (
        .clk(clk), .nrst(nrst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_done(init_done), .r0_drop(r0_drop),
        .byp_addrA(byp_addrA), .byp_addrB(byp_addrB),
        .byp_hitA(byp_hitA), .byp_hitB(byp_hitB),
        .byp_dataA(byp_dataA), .byp_dataB(byp_dataB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        mv; logic [4:0] ma; logic [31:0] md;
        logic [4:0]  ba; logic [4:0] bb;
        logic        e_ar; logic e_mr; logic e_we;
        logic [4:0]  e_wa; logic [31:0] e_wd; logic e_r0;
        logic        e_ha; logic [31:0] e_da;
        logic        e_hb; logic [31:0] e_db;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Assert reset for n edges and check the reset state, then release at a negedge.
    task automatic do_reset(input int n);
        @(negedge clk);
        nrst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_r0_drop", {31'd0, r0_drop}, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        @(negedge clk);
        nrst = 1'b0;
    endtask

    // Follow the 31-write clear with both sources requesting throughout.
    task automatic run_clear();
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h8888;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h9999;
        byp_addrA = 5'd29; byp_addrB = 5'd0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            chk("clr_wr_en", {31'd0, wr_en}, 32'd1);
            chk("clr_wr_addr", {27'd0, wr_addr}, k);
            chk("clr_wr_data", wr_data, (k == 29) ? 32'd252 : 32'd0);
            chk("clr_init_done", {31'd0, init_done}, 32'd0);
            chk("clr_readies", {30'd0, alu_ready, mem_ready}, 32'd0);
            chk("clr_byp_hitA", {31'd0, byp_hitA}, (k == 29) ? 32'd1 : 32'd0);
            chk("clr_byp_dataA", byp_dataA, (k == 29) ? 32'd252 : 32'd0);
            chk("clr_byp_hitB", {31'd0, byp_hitB}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("clr_end_wr_en", {31'd0, wr_en}, 32'd0);
        chk("clr_end_init_done", {31'd0, init_done}, 32'd1);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           av aa     ad            mv ma     md           ba     bb     ar    mr    we    wa     wd            r0    ha    da            hb    db
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    5'd5,  5'd6,  1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 5'd3,  32'h3,        1'b1, 5'd4,  32'h4,    5'd3,  5'd4,  1'b0, 1'b1, 1'b1, 5'd4,  32'h4,        1'b0, 1'b0, 32'h0,        1'b1, 32'h4};
        vecs[2]  = '{1'b1, 5'd3,  32'h3,        1'b1, 5'd4,  32'h4,    5'd3,  5'd4,  1'b1, 1'b0, 1'b1, 5'd3,  32'h3,        1'b0, 1'b1, 32'h3,        1'b0, 32'h0};
        vecs[3]  = '{1'b1, 5'd3,  32'h3,        1'b1, 5'd4,  32'h4,    5'd3,  5'd4,  1'b0, 1'b1, 1'b1, 5'd4,  32'h4,        1'b0, 1'b0, 32'h0,        1'b1, 32'h4};
        vecs[4]  = '{1'b1, 5'd3,  32'h3,        1'b1, 5'd4,  32'h4,    5'd3,  5'd4,  1'b1, 1'b0, 1'b1, 5'd3,  32'h3,        1'b0, 1'b1, 32'h3,        1'b0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd3,  5'd3,  1'b0, 1'b0, 1'b0, 5'd3,  32'h3,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234, 5'd0,  5'd3,  1'b0, 1'b1, 1'b0, 5'd3,  32'h3,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd3,  32'h3,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[8]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,    5'd31, 5'd0,  1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 5'd1,  32'h1,        1'b0, 5'd0,  32'h0,    5'd1,  5'd1,  1'b1, 1'b0, 1'b1, 5'd1,  32'h1,        1'b0, 1'b1, 32'h1,        1'b1, 32'h1};
        vecs[10] = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd30, 32'h3030, 5'd30, 5'd2,  1'b0, 1'b1, 1'b1, 5'd30, 32'h3030,     1'b0, 1'b1, 32'h3030,     1'b0, 32'h0};
        vecs[11] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd6,  32'h6,    5'd30, 5'd6,  1'b1, 1'b0, 1'b0, 5'd30, 32'h3030,     1'b1, 1'b0, 32'h0,        1'b0, 32'h0};

        nrst = 1'b1;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
        byp_addrA = 5'd0; byp_addrB = 5'd0;

        // Power-on reset held two cycles, then the full clear.
        do_reset(2);
        run_clear();

        // Table-driven RUN vectors: readiness before the edge, port and bypass after.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            byp_addrA = vecs[i].ba; byp_addrB = vecs[i].bb;
            #1;
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
            chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_mr});
            @(posedge clk);
            #1;
            alu_valid = 1'b0;
            mem_valid = 1'b0;
            chk($sformatf("v%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].e_we});
            if (vecs[i].e_we || !vecs[i].e_r0) begin
                chk($sformatf("v%0d_wr_addr", i), {27'd0, wr_addr}, {27'd0, vecs[i].e_wa});
                chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wd);
            end
            chk($sformatf("v%0d_r0_drop", i), {31'd0, r0_drop}, {31'd0, vecs[i].e_r0});
            chk($sformatf("v%0d_hitA", i), {31'd0, byp_hitA}, {31'd0, vecs[i].e_ha});
            chk($sformatf("v%0d_dataA", i), byp_dataA, vecs[i].e_da);
            chk($sformatf("v%0d_hitB", i), {31'd0, byp_hitB}, {31'd0, vecs[i].e_hb});
            chk($sformatf("v%0d_dataB", i), byp_dataB, vecs[i].e_db);
            chk($sformatf("v%0d_init_done", i), {31'd0, init_done}, 32'd1);
        end

        // Reset in RUN with an ALU result pending: it must never be written.
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("runrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("runrst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("runrst_init_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        nrst = 1'b0;
        run_clear();

        // Reset in the middle of the clear restarts it at r1.
        do_reset(1);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (wr_en && wr_addr == 5'd10) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("midclr_reach_10", {31'd0, found}, 32'd1);
        end
        do_reset(1);
        run_clear();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_writeback
